mips_multicycle_control: RTL

Multicycle MIPS control unit: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over several clocks, sharing one ALU and one memory port. It replaces the single-cycle opcode/ALU decode path in the multicycle datapath. It adds:
- a memory ready/request handshake with a configurable timeout;
- optional extended opcodes (addi, bne, j);
- a sticky fault state.

---
 rtl/mips_multicycle_control_pkg.sv | 67 ++++++
 rtl/mips_multicycle_control_alu_dec.sv | 32 +++
 rtl/mips_multicycle_control.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// FSM states, opcode/funct constants, mux encodings and the strobe bundle.
package MIPS_MC_Definitions;

    typedef logic [5:0] opcode_t;
    typedef logic [5:0] function_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_sel_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXECUTE, S_ALU_WB, S_BRANCH, S_ADDI_EXEC, S_ADDI_WB, S_JUMP, S_FAULT
    } mc_state_t;

    localparam opcode_t OP_RTYPE = 6'h00;
    localparam opcode_t OP_LW    = 6'h23;
    localparam opcode_t OP_SW    = 6'h2B;
    localparam opcode_t OP_BEQ   = 6'h04;
    localparam opcode_t OP_BNE   = 6'h05;
    localparam opcode_t OP_ADDI  = 6'h08;
    localparam opcode_t OP_J     = 6'h02;

    localparam function_t FN_ADD = 6'h20;
    localparam function_t FN_SUB = 6'h22;
    localparam function_t FN_AND = 6'h24;
    localparam function_t FN_OR  = 6'h25;
    localparam function_t FN_SLT = 6'h2A;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        alu_op_t    alu_op;
        logic       alu_en;
        logic       instr_retired;
    } mc_control_t;

endpackage

// File: rtl/mips_multicycle_control_alu_dec.sv
// ALU decoder: maps the FSM's alu_op plus the R-type funct field to an ALU select,
// flagging funct codes the ALU does not implement.
module mips_multicycle_control_alu_dec
    import MIPS_MC_Definitions::*;
(
    input  alu_op_t   alu_op_i,
    input  function_t funct_i,
    output alu_sel_t  alu_sel_o,
    output logic      invalid_funct_o
);

    always_comb begin
        alu_sel_o       = ALU_AND;
        invalid_funct_o = 1'b0;
        case (alu_op_i)
            ALU_OP_ADD: alu_sel_o = ALU_ADD;
            ALU_OP_SUB: alu_sel_o = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_sel_o = ALU_ADD;
                    FN_SUB:  alu_sel_o = ALU_SUB;
                    FN_AND:  alu_sel_o = ALU_AND;
                    FN_OR:   alu_sel_o = ALU_OR;
                    FN_SLT:  alu_sel_o = ALU_SLT;
                    default: invalid_funct_o = 1'b1;
                endcase
            end
            default: invalid_funct_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with a memory ready/request handshake, optional
// addi/bne/j support, a wait-cycle timeout and a sticky, reset-only FAULT state.
module mips_multicycle_control
    import MIPS_MC_Definitions::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit ENABLE_EXT_OPS = 1'b1,
    parameter int TMO_W          = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  opcode_t   opcode,
    input  function_t funct,
    input  logic      zero,
    input  logic      mem_ready,
    output logic      mem_req,
    output logic      mem_we,
    output logic      iord,
    output logic      ir_write,
    output logic      pc_write,
    output logic      reg_write,
    output logic      reg_dst,
    output logic      mem_to_reg,
    output logic      alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output alu_sel_t  alu_sel,
    output logic      instr_retired,
    output logic      illegal_op,
    output logic      mem_timeout
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    mc_state_t          state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;
    mc_control_t        ctl, ctl_gated;
    alu_sel_t           dec_sel;
    logic               dec_invalid;
    logic               in_mem_state;
    logic               tmo_hit;

    mips_multicycle_control_alu_dec u_alu_dec (
        .alu_op_i        (ctl.alu_op),
        .funct_i         (funct),
        .alu_sel_o       (dec_sel),
        .invalid_funct_o (dec_invalid)
    );

    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                          (state_q == S_MEM_WRITE);
    // Completion on the limit cycle wins, hence the !mem_ready term.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && in_mem_state && !mem_ready &&
                     (tmo_q == TMO_LAST);

    always_comb begin
        ctl       = '0;
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_FETCH: begin
                ctl.mem_req   = 1'b1;
                ctl.alu_en    = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.pc_src    = PCSRC_ALU;
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                ctl.alu_en    = 1'b1;
                ctl.alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_BNE:       state_d = ENABLE_EXT_OPS ? S_BRANCH : S_FAULT;
                    OP_ADDI:      state_d = ENABLE_EXT_OPS ? S_ADDI_EXEC : S_FAULT;
                    OP_J:         state_d = ENABLE_EXT_OPS ? S_JUMP : S_FAULT;
                    default:      state_d = S_FAULT;
                endcase
                if (state_d == S_FAULT) illegal_d = 1'b1;
            end
            S_MEM_ADDR: begin
                ctl.alu_en    = 1'b1;
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                state_d       = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                ctl.mem_req = 1'b1;
                ctl.iord    = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctl.reg_write     = 1'b1;
                ctl.mem_to_reg    = 1'b1;
                ctl.instr_retired = 1'b1;
                state_d           = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctl.mem_req = 1'b1;
                ctl.mem_we  = 1'b1;
                ctl.iord    = 1'b1;
                if (mem_ready) begin
                    ctl.instr_retired = 1'b1;
                    state_d           = S_FETCH;
                end
            end
            S_EXECUTE: begin
                ctl.alu_en    = 1'b1;
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = ALU_OP_FUNCT;
                if (dec_invalid) begin
                    state_d   = S_FAULT;
                    illegal_d = 1'b1;
                end else begin
                    state_d   = S_ALU_WB;
                end
            end
            S_ALU_WB: begin
                ctl.reg_write     = 1'b1;
                ctl.reg_dst       = 1'b1;
                ctl.instr_retired = 1'b1;
                state_d           = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_en        = 1'b1;
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = SRCB_B;
                ctl.alu_op        = ALU_OP_SUB;
                ctl.pc_src        = PCSRC_ALUOUT;
                ctl.pc_write      = (opcode == OP_BNE) ? !zero : zero;
                ctl.instr_retired = 1'b1;
                state_d           = S_FETCH;
            end
            S_ADDI_EXEC: begin
                ctl.alu_en    = 1'b1;
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                state_d       = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctl.reg_write     = 1'b1;
                ctl.instr_retired = 1'b1;
                state_d           = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_src        = PCSRC_JUMP;
                ctl.pc_write      = 1'b1;
                ctl.instr_retired = 1'b1;
                state_d           = S_FETCH;
            end
            default: state_d = S_FAULT;
        endcase
        if (tmo_hit) begin
            state_d   = S_FAULT;
            timeout_d = 1'b1;
        end
    end

    // Any state change restarts the wait count, so each memory state starts at zero.
    always_comb begin
        if (state_d != state_q)              tmo_d = '0;
        else if (in_mem_state && !mem_ready) tmo_d = tmo_q + TMO_W'(1);
        else                                 tmo_d = tmo_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            tmo_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs are forced low combinationally so reset suppresses writes at once.
    assign ctl_gated     = rst_n ? ctl : '0;
    assign mem_req       = ctl_gated.mem_req;
    assign mem_we        = ctl_gated.mem_we;
    assign iord          = ctl_gated.iord;
    assign ir_write      = ctl_gated.ir_write;
    assign pc_write      = ctl_gated.pc_write;
    assign reg_write     = ctl_gated.reg_write;
    assign reg_dst       = ctl_gated.reg_dst;
    assign mem_to_reg    = ctl_gated.mem_to_reg;
    assign alu_src_a     = ctl_gated.alu_src_a;
    assign alu_src_b     = ctl_gated.alu_src_b;
    assign pc_src        = ctl_gated.pc_src;
    assign instr_retired = ctl_gated.instr_retired;
    assign alu_sel       = ctl_gated.alu_en ? dec_sel : ALU_AND;
    assign illegal_op    = rst_n & illegal_q;
    assign mem_timeout   = rst_n & timeout_q;

endmodule
